// File: rtl/ads131_pkg.sv
// Shared opcode constants, command and state enums for the ADS131E08 SPI sequencer.
package ads131_pkg;

    localparam logic [7:0] OPC_RDATA = 8'h12;
    localparam logic [7:0] OPC_RREG  = 8'h20;
    localparam logic [7:0] OPC_WREG  = 8'h40;

    typedef enum logic [1:0] {
        OP_OPCODE = 2'd0,
        OP_WREG   = 2'd1,
        OP_RREG   = 2'd2,
        OP_RDATA  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_TX,
        ST_RX,
        ST_GAP
    } state_e;

endpackage

// File: rtl/ads131_spi_seq_if.sv
// Command-side and SPI-engine-side signals of the sequencer; master is the sequencer.
interface ads131_spi_seq_if;

    logic       I_cmd_valid;
    logic       O_cmd_ready;
    logic [1:0] I_cmd_op;
    logic [7:0] I_cmd_opcode;
    logic [4:0] I_cmd_addr;
    logic [7:0] I_cmd_wdata;
    logic       O_rd_valid;
    logic [7:0] O_rd_data;
    logic       O_byte_valid;
    logic [7:0] O_byte_data;
    logic       O_byte_last;
    logic       O_err;
    logic       O_eng_spi_en;
    logic       O_eng_tx_en;
    logic       O_eng_rx_en;
    logic [7:0] O_eng_tx_data;
    logic       I_eng_tx_done;
    logic       I_eng_rx_done;
    logic [7:0] I_eng_rx_data;

    modport master (
        input  I_cmd_valid, I_cmd_op, I_cmd_opcode, I_cmd_addr, I_cmd_wdata,
        input  I_eng_tx_done, I_eng_rx_done, I_eng_rx_data,
        output O_cmd_ready, O_rd_valid, O_rd_data, O_byte_valid, O_byte_data,
        output O_byte_last, O_err, O_eng_spi_en, O_eng_tx_en, O_eng_rx_en, O_eng_tx_data
    );

    modport slave (
        output I_cmd_valid, I_cmd_op, I_cmd_opcode, I_cmd_addr, I_cmd_wdata,
        output I_eng_tx_done, I_eng_rx_done, I_eng_rx_data,
        input  O_cmd_ready, O_rd_valid, O_rd_data, O_byte_valid, O_byte_data,
        input  O_byte_last, O_err, O_eng_spi_en, O_eng_tx_en, O_eng_rx_en, O_eng_tx_data
    );

endinterface

// File: rtl/ads131_spi_seq.sv
// Expands one OPCODE/WREG/RREG/RDATA command into ADS131E08 byte strobes with a
// fixed rearm gap between bytes, returning read results as single-cycle pulses.
module ads131_spi_seq
    import ads131_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = 27,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              I_clk,
    input  logic              I_rst,
    ads131_spi_seq_if.master  bus
);

    localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYC - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [5:0]  FRAME_END = 6'(FRAME_BYTES);
    localparam logic [5:0]  RDATA_LEN = 6'(FRAME_BYTES + 1);

    state_e      r_state, w_next;
    op_e         r_op;
    logic [7:0]  r_opcode, r_wdata;
    logic [4:0]  r_addr;
    logic [5:0]  r_idx;
    logic [3:0]  r_gap;
    logic [15:0] r_to;
    logic        r_abort, r_spi_en;
    logic        r_rd_valid, r_byte_valid, r_byte_last, r_err;
    logic [7:0]  r_rd_data, r_byte_data;

    logic        w_accept, w_done, w_tmo, w_is_tx;
    logic [5:0]  w_total;
    logic [7:0]  w_tx_byte;

    // Byte plan for the latched command, indexed by bytes already completed.
    always_comb begin
        w_tx_byte = '0;
        w_is_tx   = 1'b1;
        w_total   = 6'd1;
        case (r_op)
            OP_OPCODE: w_tx_byte = r_opcode;
            OP_WREG: begin
                w_total = 6'd3;
                if (r_idx == 6'd0)      w_tx_byte = OPC_WREG | {3'b000, r_addr};
                else if (r_idx == 6'd1) w_tx_byte = '0;
                else                    w_tx_byte = r_wdata;
            end
            OP_RREG: begin
                w_total = 6'd3;
                w_is_tx = (r_idx < 6'd2);
                if (r_idx == 6'd0) w_tx_byte = OPC_RREG | {3'b000, r_addr};
            end
            OP_RDATA: begin
                w_total   = RDATA_LEN;
                w_is_tx   = (r_idx == 6'd0);
                w_tx_byte = OPC_RDATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) r_state <= ST_RST;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        w_tmo    = 1'b0;
        case (r_state)
            ST_RST:  w_next = ST_IDLE;
            ST_IDLE: if (bus.I_cmd_valid) begin
                w_accept = 1'b1;
                w_next   = ST_TX;
            end
            ST_TX: if (bus.I_eng_tx_done) begin
                w_done = 1'b1;
                w_next = ST_GAP;
            end else if (r_to == TO_LAST) begin
                w_tmo  = 1'b1;
                w_next = ST_GAP;
            end
            ST_RX: if (bus.I_eng_rx_done) begin
                w_done = 1'b1;
                w_next = ST_GAP;
            end else if (r_to == TO_LAST) begin
                w_tmo  = 1'b1;
                w_next = ST_GAP;
            end
            ST_GAP: if (r_gap == GAP_LAST) begin
                if (r_abort || r_idx == w_total) w_next = ST_IDLE;
                else if (w_is_tx)                w_next = ST_TX;
                else                             w_next = ST_RX;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_op         <= OP_OPCODE;
            r_opcode     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_idx        <= '0;
            r_gap        <= '0;
            r_to         <= '0;
            r_abort      <= 1'b0;
            r_spi_en     <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_byte_last  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rd_valid   <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_last  <= 1'b0;
            r_err        <= 1'b0;
            if (r_state == ST_TX || r_state == ST_RX) r_to <= r_to + 16'd1;
            else                                      r_to <= '0;
            if (r_state == ST_GAP) r_gap <= r_gap + 4'd1;
            if (w_accept) begin
                r_op     <= op_e'(bus.I_cmd_op);
                r_opcode <= bus.I_cmd_opcode;
                r_addr   <= bus.I_cmd_addr;
                r_wdata  <= bus.I_cmd_wdata;
                r_idx    <= '0;
                r_abort  <= 1'b0;
                r_spi_en <= 1'b1;
            end
            if (w_done) begin
                r_idx <= r_idx + 6'd1;
                r_gap <= '0;
                if (r_state == ST_RX) begin
                    if (r_op == OP_RREG) begin
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= bus.I_eng_rx_data;
                    end else begin
                        r_byte_valid <= 1'b1;
                        r_byte_data  <= bus.I_eng_rx_data;
                        r_byte_last  <= (r_idx == FRAME_END);
                    end
                end
            end
            if (w_tmo) begin
                r_abort <= 1'b1;
                r_err   <= 1'b1;
                r_gap   <= '0;
            end
        end
    end

    assign bus.O_cmd_ready   = (r_state == ST_IDLE);
    assign bus.O_eng_tx_en   = (r_state == ST_TX);
    assign bus.O_eng_rx_en   = (r_state == ST_RX);
    assign bus.O_eng_tx_data = (r_state == ST_TX) ? w_tx_byte : '0;
    assign bus.O_eng_spi_en  = r_spi_en;
    assign bus.O_rd_valid    = r_rd_valid;
    assign bus.O_rd_data     = r_rd_data;
    assign bus.O_byte_valid  = r_byte_valid;
    assign bus.O_byte_data   = r_byte_data;
    assign bus.O_byte_last   = r_byte_last;
    assign bus.O_err         = r_err;

endmodule

// File: tb/tb_ads131_spi_seq.sv
// Bench for ads131_spi_seq: randomized-latency engine model, command-level byte
// plan model, per-scenario checks of sequencing, timing, timeout and reset.
module tb_ads131_spi_seq;

    localparam int unsigned FRAME = 27;
    localparam int unsigned GAP   = 4;
    localparam int unsigned TMO   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ads131_spi_seq_if bus();

    ads131_spi_seq #(.FRAME_BYTES(FRAME), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus)
    );

    int tests_run = 0;
    int fails     = 0;

    logic [31:0] all_out;
    assign all_out = {bus.O_cmd_ready, bus.O_rd_valid, bus.O_rd_data, bus.O_byte_valid,
                      bus.O_byte_data, bus.O_byte_last, bus.O_err, bus.O_eng_spi_en,
                      bus.O_eng_tx_en, bus.O_eng_rx_en, bus.O_eng_tx_data};

    // Engine model: done rises after a random latency while the strobe is high.
    bit          stall = 1'b0;
    int unsigned tcnt, tlat, rcnt, rlat;
    logic [7:0]  rx_b;
    logic [7:0]  tx_log[$], rx_sent[$], rx_src[$], rd_log[$], exp_tx[$];
    logic [8:0]  byte_log[$];
    int unsigned gap_log[$];
    int unsigned last_cnt, err_cnt, overlap, rx_cyc, busy_cyc, hi_cyc, low_run;

    always @(posedge clk) begin
        if (rst || !bus.O_eng_tx_en) begin
            bus.I_eng_tx_done <= 1'b0;
            tcnt <= 0;
            tlat <= $urandom_range(0, 3);
        end else if (!stall && !bus.I_eng_tx_done) begin
            if (tcnt == tlat) begin
                bus.I_eng_tx_done <= 1'b1;
                tx_log.push_back(bus.O_eng_tx_data);
            end else tcnt <= tcnt + 1;
        end
        if (rst) bus.I_eng_rx_data <= 8'h00;
        if (rst || !bus.O_eng_rx_en) begin
            bus.I_eng_rx_done <= 1'b0;
            rcnt <= 0;
            rlat <= $urandom_range(0, 3);
        end else if (!stall && !bus.I_eng_rx_done) begin
            if (rcnt == rlat) begin
                rx_b = (rx_src.size() > 0) ? rx_src.pop_front() : 8'($urandom);
                bus.I_eng_rx_data <= rx_b;
                bus.I_eng_rx_done <= 1'b1;
                rx_sent.push_back(rx_b);
            end else rcnt <= rcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.O_rd_valid)   rd_log.push_back(bus.O_rd_data);
            if (bus.O_byte_valid) byte_log.push_back({bus.O_byte_last, bus.O_byte_data});
            if (bus.O_byte_last)  last_cnt++;
            if (bus.O_err)        err_cnt++;
            if (bus.O_eng_tx_en && bus.O_eng_rx_en) overlap++;
            if (bus.O_eng_rx_en)  rx_cyc++;
            if (!bus.O_cmd_ready) busy_cyc++;
            if (bus.O_eng_tx_en || bus.O_eng_rx_en) begin
                hi_cyc++;
                if (low_run > 0) gap_log.push_back(low_run);
                low_run = 0;
            end else if (!bus.O_cmd_ready) low_run++;
            else low_run = 0;
        end
    end

    task automatic clear_logs();
        @(posedge clk);
        tx_log.delete(); rx_sent.delete(); rx_src.delete(); rd_log.delete();
        byte_log.delete(); gap_log.delete();
        last_cnt = 0; err_cnt = 0; rx_cyc = 0; busy_cyc = 0; hi_cyc = 0; low_run = 0;
    endtask

    // Expected command bytes and read count, straight from the ADC command table.
    int unsigned exp_nrx;
    task automatic model_cmd(input logic [1:0] op, input logic [7:0] opc,
                             input logic [4:0] addr, input logic [7:0] wd);
        exp_tx.delete();
        exp_nrx = 0;
        case (op)
            2'd0: exp_tx.push_back(opc);
            2'd1: begin exp_tx.push_back(8'h40 + {3'b0, addr}); exp_tx.push_back(8'h00); exp_tx.push_back(wd); end
            2'd2: begin exp_tx.push_back(8'h20 + {3'b0, addr}); exp_tx.push_back(8'h00); exp_nrx = 1; end
            default: begin exp_tx.push_back(8'h12); exp_nrx = FRAME; end
        endcase
    endtask

    function automatic bit q_match(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit gaps_ok(input int unsigned n);
        if (gap_log.size() != n) return 1'b0;
        foreach (gap_log[i]) if (gap_log[i] != GAP) return 1'b0;
        return 1'b1;
    endfunction

    // Returns at the negedge of the first busy cycle after acceptance.
    task automatic issue(input logic [1:0] op, input logic [7:0] opc, input logic [4:0] addr,
                         input logic [7:0] wd, input int unsigned hold);
        int unsigned n = 0;
        @(negedge clk);
        while (!bus.O_cmd_ready && n < 500) begin @(negedge clk); n++; end
        bus.I_cmd_valid = 1'b1; bus.I_cmd_op = op; bus.I_cmd_opcode = opc;
        bus.I_cmd_addr = addr;  bus.I_cmd_wdata = wd;
        @(negedge clk);
        for (int unsigned i = 0; i < hold; i++) begin
            bus.I_cmd_op = 2'($urandom); bus.I_cmd_opcode = 8'($urandom);
            bus.I_cmd_addr = 5'($urandom); bus.I_cmd_wdata = 8'($urandom);
            @(negedge clk);
        end
        bus.I_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        while (!bus.O_cmd_ready && n < 2000) begin @(negedge clk); n++; end
        tests_run++;
        if (bus.O_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_idle: ready=%b after %0d cycles, want 1", name, bus.O_cmd_ready, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (all_out !== 32'h0) begin fails++; $display("FAIL reset_outputs: got %h want 00000000", all_out); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.O_cmd_ready, bus.O_eng_spi_en} !== 2'b10) begin
            fails++; $display("FAIL reset_release: ready,spi_en=%b want 10", {bus.O_cmd_ready, bus.O_eng_spi_en});
        end
    endtask

    task automatic test_opcode();
        int unsigned n = 0, cnt = 0, bad = 0;
        clear_logs();
        issue(2'd0, 8'h0A, 5'd0, 8'h00, 0);
        tests_run++;
        if ({bus.O_cmd_ready, bus.O_eng_tx_en, bus.O_eng_spi_en} !== 3'b011) begin
            fails++; $display("FAIL accept_timing: ready,tx_en,spi_en=%b want 011",
                              {bus.O_cmd_ready, bus.O_eng_tx_en, bus.O_eng_spi_en});
        end
        while (!(bus.O_eng_tx_en && bus.I_eng_tx_done) && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        while (!bus.O_cmd_ready && cnt < 100) begin
            if (bus.O_eng_tx_en || bus.O_eng_rx_en) bad++;
            cnt++;
            @(negedge clk);
        end
        tests_run++;
        if (cnt != GAP || bad != 0) begin
            fails++; $display("FAIL opcode_gap: low cycles=%0d strobe-high=%0d want %0d/0", cnt, bad, GAP);
        end
        model_cmd(2'd0, 8'h0A, 5'd0, 8'h00);
        tests_run++;
        if (!q_match(tx_log, exp_tx)) begin
            fails++; $display("FAIL opcode_tx: %0d bytes first=%h want 1 byte 0a",
                              tx_log.size(), (tx_log.size() > 0) ? tx_log[0] : 8'hxx);
        end
    endtask

    task automatic test_wreg();
        clear_logs();
        issue(2'd1, 8'h00, 5'h01, 8'h96, 3);
        wait_idle("wreg");
        model_cmd(2'd1, 8'h00, 5'h01, 8'h96);
        tests_run++;
        if (!q_match(tx_log, exp_tx)) begin
            fails++; $display("FAIL wreg_tx: got %p want %p", tx_log, exp_tx);
        end
        tests_run++;
        if (rx_cyc != 0 || rd_log.size() != 0 || byte_log.size() != 0) begin
            fails++; $display("FAIL wreg_no_read: rx_cyc=%0d rd=%0d bytes=%0d want 0/0/0",
                              rx_cyc, rd_log.size(), byte_log.size());
        end
        tests_run++;
        if (!gaps_ok(2) || busy_cyc != hi_cyc + 3 * GAP) begin
            fails++; $display("FAIL wreg_timing: gaps=%p busy=%0d want %0d", gap_log, busy_cyc, hi_cyc + 3 * GAP);
        end
    endtask

    task automatic test_rreg();
        clear_logs();
        rx_src.push_back(8'hD2);
        issue(2'd2, 8'h00, 5'h00, 8'h00, 0);
        wait_idle("rreg");
        model_cmd(2'd2, 8'h00, 5'h00, 8'h00);
        tests_run++;
        if (!q_match(tx_log, exp_tx)) begin
            fails++; $display("FAIL rreg_tx: got %p want %p", tx_log, exp_tx);
        end
        tests_run++;
        if (rd_log.size() != 1 || rd_log[0] !== 8'hD2 || bus.O_rd_data !== 8'hD2 || byte_log.size() != 0) begin
            fails++; $display("FAIL rreg_data: pulses=%0d data=%h bytes=%0d want 1 d2 0",
                              rd_log.size(), bus.O_rd_data, byte_log.size());
        end
    endtask

    task automatic test_rdata();
        bit ok = 1'b1;
        clear_logs();
        for (int i = 0; i < FRAME; i++) rx_src.push_back(8'(i));
        issue(2'd3, 8'h00, 5'h00, 8'h00, 0);
        wait_idle("rdata");
        if (byte_log.size() != FRAME) ok = 1'b0;
        else foreach (byte_log[i]) if (byte_log[i] !== {(i == FRAME - 1), 8'(i)}) ok = 1'b0;
        tests_run++;
        if (!ok || last_cnt != 1) begin
            fails++; $display("FAIL rdata_frame: %0d bytes last_cnt=%0d want %0d/1", byte_log.size(), last_cnt, FRAME);
        end
        tests_run++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h12 || !gaps_ok(FRAME)) begin
            fails++; $display("FAIL rdata_seq: tx=%p gaps=%0d want 12 and %0d gaps", tx_log, gap_log.size(), FRAME);
        end
    endtask

    task automatic test_random();
        logic [1:0] op; logic [7:0] opc, wd; logic [4:0] addr;
        bit ok;
        for (int k = 0; k < 20; k++) begin
            op = 2'($urandom); opc = 8'($urandom); addr = 5'($urandom); wd = 8'($urandom);
            clear_logs();
            issue(op, opc, addr, wd, $urandom_range(0, 2));
            wait_idle("random");
            model_cmd(op, opc, addr, wd);
            ok = q_match(tx_log, exp_tx) && (rx_sent.size() == exp_nrx)
                 && (busy_cyc == hi_cyc + (exp_tx.size() + exp_nrx) * GAP) && (err_cnt == 0);
            if (exp_nrx == 1) ok = ok && rd_log.size() == 1 && rd_log[0] === rx_sent[0] && byte_log.size() == 0;
            else if (exp_nrx == FRAME) begin
                ok = ok && rd_log.size() == 0 && byte_log.size() == FRAME && last_cnt == 1;
                if (ok) foreach (byte_log[i]) if (byte_log[i] !== {(i == FRAME - 1), rx_sent[i]}) ok = 1'b0;
            end else ok = ok && rd_log.size() == 0 && byte_log.size() == 0;
            tests_run++;
            if (!ok) begin
                fails++; $display("FAIL random_cmd%0d op=%0d: tx=%0d rx=%0d rd=%0d bytes=%0d busy=%0d hi=%0d want tx=%0d rx=%0d",
                                  k, op, tx_log.size(), rx_sent.size(), rd_log.size(), byte_log.size(),
                                  busy_cyc, hi_cyc, exp_tx.size(), exp_nrx);
            end
        end
    endtask

    task automatic test_timeout();
        int unsigned n = 0, c = 0;
        clear_logs();
        stall = 1'b1;
        issue(2'd0, 8'h11, 5'd0, 8'h00, 0);
        while (bus.O_eng_tx_en && n < 200) begin n++; @(negedge clk); end
        tests_run++;
        if (n != TMO || bus.O_err !== 1'b1) begin
            fails++; $display("FAIL timeout_abort: tx_en cycles=%0d err=%b want %0d/1", n, bus.O_err, TMO);
        end
        while (!bus.O_cmd_ready && c < 100) begin c++; @(negedge clk); end
        tests_run++;
        if (c != GAP || err_cnt != 1 || tx_log.size() != 0 || last_cnt != 0) begin
            fails++; $display("FAIL timeout_recover: gap=%0d errs=%0d tx=%0d want %0d/1/0", c, err_cnt, tx_log.size(), GAP);
        end
        stall = 1'b0;
        clear_logs();
        issue(2'd0, 8'h08, 5'd0, 8'h00, 0);
        wait_idle("after_timeout");
        tests_run++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h08 || err_cnt != 0) begin
            fails++; $display("FAIL timeout_next_cmd: tx=%p errs=%0d want 08/0", tx_log, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned n = 0;
        clear_logs();
        issue(2'd3, 8'h00, 5'h00, 8'h00, 0);
        while (byte_log.size() < 10 && n < 1000) begin @(negedge clk); n++; end
        rst = 1'b1;
        #1;
        tests_run++;
        if (all_out !== 32'h0) begin fails++; $display("FAIL reset_mid_outputs: got %h want 00000000", all_out); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.O_cmd_ready !== 1'b1 || last_cnt != 0 || byte_log.size() != 10) begin
            fails++; $display("FAIL reset_mid_release: ready=%b last=%0d bytes=%0d want 1/0/10",
                              bus.O_cmd_ready, last_cnt, byte_log.size());
        end
    endtask

    initial begin
        bus.I_cmd_valid = 1'b0; bus.I_cmd_op = 2'd0; bus.I_cmd_opcode = 8'h00;
        bus.I_cmd_addr = 5'd0;  bus.I_cmd_wdata = 8'h00;
        overlap = 0;
        test_reset();
        test_opcode();
        test_wreg();
        test_rreg();
        test_rdata();
        test_random();
        test_timeout();
        test_reset_mid();
        test_rdata();
        tests_run++;
        if (overlap != 0) begin fails++; $display("FAIL strobe_overlap: %0d cycles want 0", overlap); end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
